circle_radius_sequencer: RTL and testbench
==========================================

// Module: circle_radius_sequencer
// PURPOSE
//  Per-frame radius controller for the circle visualiser. Tracks the peak mic sample over each video frame.
//  Updates the displayed radius only at frame boundaries, with peak-hold and linear decay.
//  Publishes radius and radius^2 so the circle draw block compares x*x+y*y against a stable value.
//  Sits between the mic sampler and the circle draw datapath.
// PARAMETERS
//  HOLD_FRAMES   4   frames a new peak is held before decay starts (0..15)
//  DECAY_STEP    2   radius decrement per frame once hold expires
//  RADIUS_MIN    0   floor for radius after decay
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  enable       in   1   1 = run; 0 = force IDLE, radius outputs cleared
//  freeze       in   1   1 = UPDATE keeps current radius/hold (peak still accumulates)
//  frame_start  in   1   1-cycle pulse at start of each VGA frame
//  sample_valid in   1   wave_sample qualifier
//  wave_sample  in   10  mic magnitude, 0..1023
//  radius       out  8   current radius, pixels
//  radius_sq    out  16  radius*radius, registered
//  radius_upd   out  1   1-cycle pulse when radius/radius_sq take new frame value
//  frame_miss   out  1   sticky: frame_start arrived in UPDATE/SQUARE; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; radius=0, radius_sq=0, radius_upd=0, frame_miss=0.
//   - Internal: peak=0, hold_cnt=0.
//  Sample scaling: s = wave_sample[9:2] (0..255). peak <= max(peak, s) on each sample_valid in ACCUM/SQUARE.
//  States:
//   - IDLE:   enable=1 and frame_start=1 -> UPDATE; peak cleared. Otherwise stay.
//   - ACCUM:  frame_start=1 -> UPDATE; a valid sample on that same cycle counts toward the closing frame.
//   - UPDATE: 1 cycle.
//       - freeze=1: radius/hold unchanged.
//       - else if peak >= radius: radius<=peak, hold_cnt<=HOLD_FRAMES.
//       - else if hold_cnt!=0: hold_cnt<=hold_cnt-1, radius unchanged.
//       - else: radius <= max(radius-DECAY_STEP, peak, RADIUS_MIN); subtraction saturates at 0, no wrap.
//       - peak <= (sample_valid ? s : 0), seeding the new frame. Next state: SQUARE.
//   - SQUARE: 1 cycle. radius_sq<=radius*radius (16 bit, max 65025); radius_upd<=1 next cycle. -> ACCUM.
//  Latency: frame_start at cycle T -> radius new at T+2 -> radius_sq new and radius_upd=1 at T+3.
//  radius_upd is high for exactly 1 cycle. It also pulses when the value is unchanged (freeze/hold).
//  frame_start during UPDATE or SQUARE: ignored, frame_miss<=1.
//  enable=0 in any state:
//   - Next cycle: state=IDLE; radius, radius_sq, peak, hold_cnt = 0; no radius_upd pulse.
//   - A pending SQUARE is abandoned.
//  enable rising: nothing changes until the next frame_start.
//  radius and radius_sq are never mutually inconsistent at a radius_upd pulse. Between the T+2 and T+3 edges, radius leads radius_sq by one cycle.
//  Reset mid-frame: immediate return to reset values; first update on the first frame_start after rst_n=1 and enable=1.
// TESTING
//  1. Reset, enable=1, frame_start, samples 400,800(s=200),100, frame_start -> radius=200, radius_sq=40000, radius_upd at T+3.
//  2. Hold/decay (HOLD=4, STEP=2): after radius=200, 6 frames of peak 0 -> 4 frames at 200, then 198, 196.
//  3. Floor: radius=3, peak=0, hold=0, STEP=2 -> 1 -> 0 -> 0 (no wrap to 254/255).
//  4. wave_sample=1023 -> radius=255, radius_sq=65025. Same-cycle frame_start+sample=1020 counts to old frame; sample in UPDATE seeds new.
//  5. freeze=1 with peak 250 over radius 100 -> radius stays 100, radius_upd still pulses. freeze=0 next frame -> 250.
//  6. frame_start at T+1 -> frame_miss=1 sticky; enable=0 mid-SQUARE -> outputs 0, no pulse. rst_n low mid-frame -> all outputs 0 async.

Source files
------------

// File: rtl/circle_radius_sequencer.sv
// Per-frame radius controller: peak-hold/decay radius and radius^2 updated only at frame boundaries.
// Latency frame_start(T) -> radius T+2 -> radius_sq/radius_upd T+3; no backpressure, frame_start during update is flagged.
module circle_radius_sequencer #(
    parameter int HOLD_FRAMES = 4,
    parameter int DECAY_STEP  = 2,
    parameter int RADIUS_MIN  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        freeze,
    input  logic        frame_start,
    input  logic        sample_valid,
    input  logic [9:0]  wave_sample,
    output logic [7:0]  radius,
    output logic [15:0] radius_sq,
    output logic        radius_upd,
    output logic        frame_miss
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_SQUARE = 2'd3;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_FRAMES);
    localparam logic [7:0] STEP      = 8'(DECAY_STEP);
    localparam logic [7:0] FLOOR     = 8'(RADIUS_MIN);

    logic [1:0] state;
    logic [7:0] peak;
    logic [3:0] hold_cnt;

    logic [7:0] samp;
    logic [7:0] peak_next;
    logic [7:0] dec_sat;
    logic [7:0] dec_pk;
    logic [7:0] decay_val;
    logic [1:0] unused_lsbs;

    assign samp        = wave_sample[9:2];
    assign unused_lsbs = wave_sample[1:0];
    assign peak_next   = (sample_valid && (samp > peak)) ? samp : peak;

    // Decay saturates at zero, then is clamped up to the frame peak and the floor.
    assign dec_sat   = (radius > STEP) ? (radius - STEP) : 8'd0;
    assign dec_pk    = (dec_sat > peak) ? dec_sat : peak;
    assign decay_val = (dec_pk > FLOOR) ? dec_pk : FLOOR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            radius     <= 8'd0;
            radius_sq  <= 16'd0;
            radius_upd <= 1'b0;
            frame_miss <= 1'b0;
            peak       <= 8'd0;
            hold_cnt   <= 4'd0;
        end else begin
            radius_upd <= 1'b0;
            if (frame_start && ((state == S_UPDATE) || (state == S_SQUARE)))
                frame_miss <= 1'b1;

            if (!enable) begin
                state     <= S_IDLE;
                radius    <= 8'd0;
                radius_sq <= 16'd0;
                peak      <= 8'd0;
                hold_cnt  <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            state <= S_UPDATE;
                            peak  <= 8'd0;
                        end
                    end
                    S_ACCUM: begin
                        peak <= peak_next;
                        if (frame_start)
                            state <= S_UPDATE;
                    end
                    S_UPDATE: begin
                        if (!freeze) begin
                            if (peak >= radius) begin
                                radius   <= peak;
                                hold_cnt <= HOLD_INIT;
                            end else if (hold_cnt != 4'd0) begin
                                hold_cnt <= hold_cnt - 4'd1;
                            end else begin
                                radius <= decay_val;
                            end
                        end
                        // A sample landing in the update cycle opens the next frame.
                        peak  <= sample_valid ? samp : 8'd0;
                        state <= S_SQUARE;
                    end
                    S_SQUARE: begin
                        peak       <= peak_next;
                        radius_sq  <= 16'(radius) * 16'(radius);
                        radius_upd <= 1'b1;
                        state      <= S_ACCUM;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_circle_radius_sequencer.sv
// Directed bench: per-frame vector tables plus hand sequences for miss, enable drop, seeding and reset.
module tb_circle_radius_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        freeze;
    logic        frame_start;
    logic        sample_valid;
    logic [9:0]  wave_sample;
    logic [7:0]  radius;
    logic [15:0] radius_sq;
    logic        radius_upd;
    logic        frame_miss;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  s0;
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic        frz;
        logic [7:0]  r;
        logic [15:0] rsq;
    } vec_t;

    vec_t va[7];
    vec_t vb[12];

    circle_radius_sequencer #(.HOLD_FRAMES(4), .DECAY_STEP(2), .RADIUS_MIN(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .freeze       (freeze),
        .frame_start  (frame_start),
        .sample_valid (sample_valid),
        .wave_sample  (wave_sample),
        .radius       (radius),
        .radius_sq    (radius_sq),
        .radius_upd   (radius_upd),
        .frame_miss   (frame_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int f,
                                input int r, input int rsq);
        vec_t v;
        v.s0 = 10'(a); v.s1 = 10'(b); v.s2 = 10'(c);
        v.frz = 1'(f); v.r = 8'(r); v.rsq = 16'(rsq);
        return v;
    endfunction

    // From ACCUM: three samples, then a frame_start at T; checks T+1..T+4.
    task automatic run_frame(input vec_t v, input string nm);
        sample_valid = 1'b1;
        wave_sample = v.s0; tick();
        wave_sample = v.s1; tick();
        wave_sample = v.s2; tick();
        sample_valid = 1'b0;
        freeze = v.frz;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk({nm, " upd@T+1"}, 32'(radius_upd), 32'd0);
        tick();
        freeze = 1'b0;
        chk({nm, " radius@T+2"}, 32'(radius), 32'(v.r));
        chk({nm, " upd@T+2"}, 32'(radius_upd), 32'd0);
        tick();
        chk({nm, " radius_sq@T+3"}, 32'(radius_sq), 32'(v.rsq));
        chk({nm, " upd@T+3"}, 32'(radius_upd), 32'd1);
        tick();
        chk({nm, " upd@T+4"}, 32'(radius_upd), 32'd0);
    endtask

    // From IDLE with enable=1: first frame_start, optional sample in the UPDATE cycle.
    task automatic idle_start(input logic seed_v, input logic [9:0] seed_w);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        sample_valid = seed_v;
        wave_sample = seed_w;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        chk("idle_start radius", 32'(radius), 32'd0);
    endtask

    initial begin
        va[0] = mk(400, 800, 100, 0, 200, 40000);
        va[1] = mk(0, 0, 0, 0, 200, 40000);
        va[2] = mk(0, 0, 0, 0, 200, 40000);
        va[3] = mk(0, 0, 0, 0, 200, 40000);
        va[4] = mk(0, 0, 0, 0, 200, 40000);
        va[5] = mk(0, 0, 0, 0, 198, 39204);
        va[6] = mk(0, 0, 0, 0, 196, 38416);

        vb[0]  = mk(12, 0, 0, 0, 3, 9);
        vb[1]  = mk(0, 0, 0, 0, 3, 9);
        vb[2]  = mk(0, 0, 0, 0, 3, 9);
        vb[3]  = mk(0, 0, 0, 0, 3, 9);
        vb[4]  = mk(0, 0, 0, 0, 3, 9);
        vb[5]  = mk(0, 0, 0, 0, 1, 1);
        vb[6]  = mk(0, 0, 0, 0, 0, 0);
        vb[7]  = mk(0, 0, 0, 0, 0, 0);
        vb[8]  = mk(400, 0, 0, 0, 100, 10000);
        vb[9]  = mk(1000, 0, 0, 1, 100, 10000);
        vb[10] = mk(1000, 0, 0, 0, 250, 62500);
        vb[11] = mk(1023, 0, 0, 0, 255, 65025);

        rst_n = 1'b0; enable = 1'b0; freeze = 1'b0; frame_start = 1'b0;
        sample_valid = 1'b0; wave_sample = 10'd0;
        tick(); tick();
        chk("reset radius", 32'(radius), 32'd0);
        chk("reset radius_sq", 32'(radius_sq), 32'd0);
        chk("reset upd", 32'(radius_upd), 32'd0);
        chk("reset miss", 32'(frame_miss), 32'd0);
        rst_n = 1'b1; enable = 1'b1;

        // IDLE ignores samples until the first frame_start.
        sample_valid = 1'b1; wave_sample = 10'd1000;
        tick(); tick();
        sample_valid = 1'b0;
        chk("idle radius", 32'(radius), 32'd0);
        idle_start(1'b0, 10'd0);
        for (int i = 0; i < 7; i++) run_frame(va[i], $sformatf("hold_decay[%0d]", i));

        // frame_start in UPDATE is a miss; enable drop in SQUARE abandons the update.
        chk("miss before", 32'(frame_miss), 32'd0);
        frame_start = 1'b1;
        tick();
        tick();
        frame_start = 1'b0;
        chk("miss set", 32'(frame_miss), 32'd1);
        chk("decay in miss frame", 32'(radius), 32'd194);
        enable = 1'b0;
        tick();
        chk("disable radius", 32'(radius), 32'd0);
        chk("disable radius_sq", 32'(radius_sq), 32'd0);
        chk("disable no pulse", 32'(radius_upd), 32'd0);
        tick();
        chk("disable no pulse later", 32'(radius_upd), 32'd0);
        enable = 1'b1;
        tick(); tick(); tick();
        chk("re-enable radius", 32'(radius), 32'd0);
        chk("re-enable upd", 32'(radius_upd), 32'd0);
        chk("miss sticky", 32'(frame_miss), 32'd1);

        idle_start(1'b0, 10'd0);
        for (int i = 0; i < 12; i++) run_frame(vb[i], $sformatf("floor_freeze[%0d]", i));

        // Seeding from the UPDATE cycle, then a sample on the frame_start cycle.
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        idle_start(1'b1, 10'd400);
        run_frame(mk(0, 0, 0, 0, 100, 10000), "seed");
        sample_valid = 1'b1; wave_sample = 10'd1020; frame_start = 1'b1;
        tick();
        sample_valid = 1'b0; frame_start = 1'b0;
        tick();
        chk("same-cycle radius", 32'(radius), 32'd255);
        tick();
        chk("same-cycle radius_sq", 32'(radius_sq), 32'd65025);
        chk("same-cycle upd", 32'(radius_upd), 32'd1);
        chk("miss still sticky", 32'(frame_miss), 32'd1);

        // Asynchronous reset mid-frame.
        sample_valid = 1'b1; wave_sample = 10'd800;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async rst radius", 32'(radius), 32'd0);
        chk("async rst radius_sq", 32'(radius_sq), 32'd0);
        chk("async rst miss", 32'(frame_miss), 32'd0);
        sample_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        idle_start(1'b0, 10'd0);
        run_frame(mk(800, 0, 0, 0, 200, 40000), "after reset");
        chk("miss clear after reset", 32'(frame_miss), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
